// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM-stage load/store controller.
// Holds the request size codes, the FSM state encoding, the lane width and
// an alignment helper used by the top level.
package mem_access_pkg;

    localparam int unsigned LANE_W = 8;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned HALF_W = 2 * LANE_W;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_ILL  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_MERGE = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // True when the request cannot be served: misaligned half/word or illegal size.
    function automatic logic is_bad_access(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = addr_lo[0];
            SIZE_WORD: bad = |addr_lo;
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering between a memory word and a sub-word request.
// Ports:
//   addr_lo_i        byte offset within the word
//   size_i           request size code
//   uns_i            1 = zero-extend loads, 0 = sign-extend
//   rword_i          word read from memory
//   wdata_i          store data (lane taken from the low bits)
//   load_data_c_o    extracted and extended load result
//   merge_data_c_o   read word with the target lane replaced (full wdata for word size)
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [1:0]        addr_lo_i,
    input  logic [1:0]        size_i,
    input  logic              uns_i,
    input  logic [DATA_W-1:0] rword_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] load_data_c_o,
    output logic [DATA_W-1:0] merge_data_c_o
);

    logic [LANE_W-1:0] lane_b;
    logic [HALF_W-1:0] lane_h;
    logic              sx_b;
    logic              sx_h;

    // Little-endian lane selection from the read word.
    always_comb begin
        lane_b = rword_i[LANE_W-1:0];
        case (addr_lo_i)
            2'd0:    lane_b = rword_i[7:0];
            2'd1:    lane_b = rword_i[15:8];
            2'd2:    lane_b = rword_i[23:16];
            default: lane_b = rword_i[31:24];
        endcase
        lane_h = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
        sx_b   = ~uns_i & lane_b[LANE_W-1];
        sx_h   = ~uns_i & lane_h[HALF_W-1];
    end

    // Load extension.
    always_comb begin
        load_data_c_o = rword_i;
        case (size_i)
            SIZE_BYTE: load_data_c_o = {{(DATA_W-LANE_W){sx_b}}, lane_b};
            SIZE_HALF: load_data_c_o = {{(DATA_W-HALF_W){sx_h}}, lane_h};
            default:   load_data_c_o = rword_i;
        endcase
    end

    // Store merge: only the addressed lane changes.
    always_comb begin
        merge_data_c_o = rword_i;
        case (size_i)
            SIZE_BYTE: begin
                case (addr_lo_i)
                    2'd0:    merge_data_c_o[7:0]   = wdata_i[7:0];
                    2'd1:    merge_data_c_o[15:8]  = wdata_i[7:0];
                    2'd2:    merge_data_c_o[23:16] = wdata_i[7:0];
                    default: merge_data_c_o[31:24] = wdata_i[7:0];
                endcase
            end
            SIZE_HALF: begin
                if (addr_lo_i[1]) merge_data_c_o[31:16] = wdata_i[15:0];
                else              merge_data_c_o[15:0]  = wdata_i[15:0];
            end
            default: merge_data_c_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store controller in front of a word-wide data memory.
// Turns byte/half/word requests into single-cycle read/write strobes, doing
// read-modify-write for sub-word stores and lane extract/extend for loads.
// Ports:
//   i_clk, i_rst_n            clock, async active-low reset
//   i_req..i_wdata            request (sampled only in IDLE)
//   o_busy, o_done, o_err     pipeline handshake / status
//   o_rdata                   extended load result, held until the next load
//   o_mem_read/_write/_addr/_wdata, i_mem_data   data memory interface
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned B = 32,
    parameter int unsigned W = 2
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_req,
    input  logic           i_we,
    input  logic [1:0]     i_size,
    input  logic           i_unsigned,
    input  logic [W+1:0]   i_addr,
    input  logic [B-1:0]   i_wdata,
    output logic           o_busy,
    output logic           o_done,
    output logic           o_err,
    output logic [B-1:0]   o_rdata,
    output logic           o_mem_read,
    output logic           o_mem_write,
    output logic [W-1:0]   o_mem_addr,
    output logic [B-1:0]   o_mem_wdata,
    input  logic [B-1:0]   i_mem_data
);

    if (B != 32) begin : g_width_check
        $error("mem_access_unit: only B=32 is supported");
    end

    state_e       state_q, state_d;
    logic         we_q, we_d;
    logic [1:0]   size_q, size_d;
    logic         uns_q, uns_d;
    logic [W+1:0] addr_q, addr_d;
    logic [B-1:0] wdata_q, wdata_d;
    logic [B-1:0] rdata_q, rdata_d;
    logic [B-1:0] mwdata_q, mwdata_d;
    logic         err_q, err_d;
    logic         busy_q, done_q, rd_q, wr_q;

    logic [B-1:0] load_data_c;
    logic [B-1:0] merge_data_c;

    mem_lane_align u_align (
        .addr_lo_i      (addr_q[1:0]),
        .size_i         (size_q),
        .uns_i          (uns_q),
        .rword_i        (i_mem_data),
        .wdata_i        (wdata_q),
        .load_data_c_o  (load_data_c),
        .merge_data_c_o (merge_data_c)
    );

    // Next-state, request latch and result updates.
    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        size_d   = size_q;
        uns_d    = uns_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        mwdata_d = mwdata_q;
        err_d    = err_q;

        case (state_q)
            ST_IDLE: begin
                if (i_req) begin
                    we_d    = i_we;
                    size_d  = i_size;
                    uns_d   = i_unsigned;
                    addr_d  = i_addr;
                    wdata_d = i_wdata;
                    err_d   = 1'b0;
                    if (is_bad_access(i_size, i_addr[1:0])) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else if (i_we && (i_size == SIZE_WORD)) begin
                        mwdata_d = i_wdata;
                        state_d  = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ:  state_d = ST_MERGE;
            ST_MERGE: begin
                // Memory data is only valid in this cycle.
                if (we_q) begin
                    mwdata_d = merge_data_c;
                    state_d  = ST_WRITE;
                end else begin
                    rdata_d = load_data_c;
                    state_d = ST_DONE;
                end
            end
            ST_WRITE: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State, latch and registered outputs (strobes follow the next state).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            we_q     <= 1'b0;
            size_q   <= SIZE_BYTE;
            uns_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            mwdata_q <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            size_q   <= size_d;
            uns_q    <= uns_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            mwdata_q <= mwdata_d;
            err_q    <= err_d;
            busy_q   <= (state_d != ST_IDLE);
            done_q   <= (state_d == ST_DONE);
            rd_q     <= (state_d == ST_READ);
            wr_q     <= (state_d == ST_WRITE);
        end
    end

    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_err       = err_q;
    assign o_rdata     = rdata_q;
    assign o_mem_read  = rd_q;
    assign o_mem_write = wr_q;
    assign o_mem_addr  = addr_q[W+1:2];
    assign o_mem_wdata = mwdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a 4-word memory model and a
// scoreboard of expected completions.
module tb_mem_access_unit;
    import mem_access_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        i_req;
    logic        i_we;
    logic [1:0]  i_size;
    logic        i_unsigned;
    logic [3:0]  i_addr;
    logic [31:0] i_wdata;
    logic        o_busy;
    logic        o_done;
    logic        o_err;
    logic [31:0] o_rdata;
    logic        o_mem_read;
    logic        o_mem_write;
    logic [1:0]  o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [31:0] mem_rdata;

    mem_access_unit #(.B(32), .W(2)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req       (i_req),
        .i_we        (i_we),
        .i_size      (i_size),
        .i_unsigned  (i_unsigned),
        .i_addr      (i_addr),
        .i_wdata     (i_wdata),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err),
        .o_rdata     (o_rdata),
        .o_mem_read  (o_mem_read),
        .o_mem_write (o_mem_write),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_data  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory model: read data valid the cycle after the read strobe, else 0.
    logic [31:0] mem [4];
    logic        pre_en;
    logic [1:0]  pre_addr;
    logic [31:0] pre_data;

    always @(posedge clk) begin
        mem_rdata <= o_mem_read ? mem[o_mem_addr] : 32'h0;
        if (o_mem_write) mem[o_mem_addr] <= o_mem_wdata;
        if (pre_en) mem[pre_addr] <= pre_data;
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nrd;
        int          nwr;
        int          wr_at;
        logic [1:0]  waddr;
        logic [31:0] wdata;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] rd_model = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    // Issue one request, push its expectation, then pop and compare at o_done.
    task automatic run_req(input string tag, input logic we, input logic [1:0] size,
                           input logic uns, input logic [3:0] addr, input logic [31:0] wdata,
                           input logic exp_err, input int exp_lat, input int nrd,
                           input int nwr, input int wr_at, input logic [31:0] exp_val);
        exp_t e;
        exp_t got;
        int   w, n, rd, wr, seen_wr_at;
        logic done, both;
        e.err   = exp_err;
        e.lat   = exp_lat;
        e.nrd   = nrd;
        e.nwr   = nwr;
        e.wr_at = wr_at;
        e.waddr = addr[3:2];
        e.wdata = exp_val;
        if (exp_err || we) e.rdata = rd_model;
        else begin
            e.rdata  = exp_val;
            rd_model = exp_val;
        end
        sb.push_back(e);

        i_req = 1'b1; i_we = we; i_size = size; i_unsigned = uns;
        i_addr = addr; i_wdata = wdata;
        w = 0;
        while (o_busy === 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (w >= 20) chk({tag, " idle"}, 32'(o_busy), 32'h0);
        @(posedge clk);

        n = 0; rd = 0; wr = 0; seen_wr_at = -1; done = 1'b0; both = 1'b0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                // Inputs must be ignored while busy.
                i_req = 1'b0; i_we = 1'($urandom); i_size = 2'($urandom);
                i_unsigned = 1'($urandom); i_addr = 4'($urandom); i_wdata = $urandom;
            end
            if (o_mem_read && o_mem_write) both = 1'b1;
            if (o_mem_read) rd++;
            if (o_mem_write) begin
                wr++;
                seen_wr_at = n;
                chk({tag, " waddr"}, 32'(o_mem_addr), 32'(sb[0].waddr));
                chk({tag, " wdata"}, o_mem_wdata, sb[0].wdata);
            end
            if (o_done) done = 1'b1;
        end

        got = sb.pop_front();
        chk({tag, " done"}, 32'(done), 32'h1);
        chk({tag, " latency"}, 32'(n), 32'(got.lat));
        chk({tag, " err"}, 32'(o_err), 32'(got.err));
        chk({tag, " rdata"}, o_rdata, got.rdata);
        chk({tag, " busy@done"}, 32'(o_busy), 32'h1);
        chk({tag, " nread"}, 32'(rd), 32'(got.nrd));
        chk({tag, " nwrite"}, 32'(wr), 32'(got.nwr));
        chk({tag, " rw_excl"}, 32'(both), 32'h0);
        if (got.nwr > 0) chk({tag, " write_cycle"}, 32'(seen_wr_at), 32'(got.wr_at));
    endtask

    initial begin
        rst_n = 1'b0; i_req = 1'b0; i_we = 1'b0; i_size = SIZE_BYTE; i_unsigned = 1'b0;
        i_addr = 4'h0; i_wdata = 32'h0; pre_en = 1'b0; pre_addr = 2'd0; pre_data = 32'h0;
        repeat (3) @(negedge clk);
        chk("reset ctrl", 32'({o_busy, o_done, o_err, o_mem_read, o_mem_write}), 32'h0);
        chk("reset rdata", o_rdata, 32'h0);
        chk("reset maddr", 32'(o_mem_addr), 32'h0);
        chk("reset mwdata", o_mem_wdata, 32'h0);
        rst_n = 1'b1;

        preload(2'd0, 32'hCAFEF00D);
        preload(2'd1, 32'h8899AABB);
        preload(2'd2, 32'h11223344);
        preload(2'd3, 32'h55667788);
        @(negedge clk);

        // Loads with lane extraction and extension.
        run_req("ld_b6_s",  1'b0, SIZE_BYTE, 1'b0, 4'h6, 32'h0, 1'b0, 3, 1, 0, 0, 32'hFFFFFF99);
        run_req("ld_h6_u",  1'b0, SIZE_HALF, 1'b1, 4'h6, 32'h0, 1'b0, 3, 1, 0, 0, 32'h00008899);
        run_req("ld_h4_s",  1'b0, SIZE_HALF, 1'b0, 4'h4, 32'h0, 1'b0, 3, 1, 0, 0, 32'hFFFFAABB);

        // Sub-word store (read-modify-write) and word store.
        run_req("st_b9",    1'b1, SIZE_BYTE, 1'b0, 4'h9, 32'h123456EE, 1'b0, 4, 1, 1, 3, 32'h1122EE44);
        chk("mem2 after st_b9", mem[2], 32'h1122EE44);
        run_req("st_wC",    1'b1, SIZE_WORD, 1'b0, 4'hC, 32'hDEADBEEF, 1'b0, 2, 0, 1, 1, 32'hDEADBEEF);
        chk("mem3 after st_wC", mem[3], 32'hDEADBEEF);

        // Misaligned and illegal requests.
        run_req("ld_w2_err", 1'b0, SIZE_WORD, 1'b0, 4'h2, 32'h0, 1'b1, 1, 0, 0, 0, 32'h0);
        run_req("st_h5_err", 1'b1, SIZE_HALF, 1'b0, 4'h5, 32'hFFFF0000, 1'b1, 1, 0, 0, 0, 32'h0);
        run_req("ld_ill",    1'b0, SIZE_ILL,  1'b0, 4'h0, 32'h0, 1'b1, 1, 0, 0, 0, 32'h0);
        run_req("st_ill",    1'b1, SIZE_ILL,  1'b0, 4'h8, 32'hA5A5A5A5, 1'b1, 1, 0, 0, 0, 32'h0);
        chk("mem1 after errs", mem[1], 32'h8899AABB);
        chk("mem2 after errs", mem[2], 32'h1122EE44);

        // Back-to-back requests across lanes; o_err must clear on accept.
        run_req("ld_w8",    1'b0, SIZE_WORD, 1'b0, 4'h8, 32'h0, 1'b0, 3, 1, 0, 0, 32'h1122EE44);
        run_req("ld_bB_u",  1'b0, SIZE_BYTE, 1'b1, 4'hB, 32'h0, 1'b0, 3, 1, 0, 0, 32'h00000011);
        run_req("st_hE",    1'b1, SIZE_HALF, 1'b0, 4'hE, 32'h9999ABCD, 1'b0, 4, 1, 1, 3, 32'hABCDBEEF);
        chk("mem3 after st_hE", mem[3], 32'hABCDBEEF);
        run_req("ld_hE_s",  1'b0, SIZE_HALF, 1'b0, 4'hE, 32'h0, 1'b0, 3, 1, 0, 0, 32'hFFFFABCD);
        run_req("ld_b7_u",  1'b0, SIZE_BYTE, 1'b1, 4'h7, 32'h0, 1'b0, 3, 1, 0, 0, 32'h00000088);

        // Reset during the READ of a sub-word store.
        @(negedge clk);
        i_req = 1'b1; i_we = 1'b1; i_size = SIZE_BYTE; i_unsigned = 1'b0;
        i_addr = 4'h5; i_wdata = 32'h00000077;
        @(posedge clk);
        @(negedge clk);
        i_req = 1'b0;
        chk("rst_mid read", 32'(o_mem_read), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid ctrl", 32'({o_busy, o_done, o_err, o_mem_read, o_mem_write}), 32'h0);
        chk("rst_mid rdata", o_rdata, 32'h0);
        chk("rst_mid maddr", 32'(o_mem_addr), 32'h0);
        rd_model = 32'h0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_mid ctrl after", 32'({o_busy, o_done, o_mem_write}), 32'h0);
        chk("mem1 after rst", mem[1], 32'h8899AABB);
        run_req("ld_w0_post", 1'b0, SIZE_WORD, 1'b0, 4'h0, 32'h0, 1'b0, 3, 1, 0, 0, 32'hCAFEF00D);
        run_req("st_b5_post", 1'b1, SIZE_BYTE, 1'b0, 4'h5, 32'h00000077, 1'b0, 4, 1, 1, 3, 32'h889977BB);
        chk("mem1 after post", mem[1], 32'h889977BB);

        chk("scoreboard empty", 32'(sb.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
